// File: rtl/llc_issue_arbiter_pkg.sv
// ============================================================================
// Module : llc_issue_arbiter_pkg
// Brief  : Shared source encodings and defaults for the LLC issue arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package llc_issue_arbiter_pkg;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    RST    = 3'd1,
    RSP    = 3'd2,
    RESUME = 3'd3,
    REQ    = 3'd4,
    DMA    = 3'd5
  } issue_src_t;

  localparam int LLC_RSP_BURST_MAX = 4;
  localparam int LLC_BUSY_TIMEOUT  = 1024;

  // Bit positions in eligibility/winner vectors; position i encodes source i+1.
  localparam int c_IDX_RST    = 0;
  localparam int c_IDX_RSP    = 1;
  localparam int c_IDX_RESUME = 2;
  localparam int c_IDX_REQ    = 3;
  localparam int c_IDX_DMA    = 4;
  localparam int c_NSRC       = 5;

  function automatic issue_src_t onehot_to_src(input logic [c_NSRC-1:0] oh);
    issue_src_t s;
    s = NONE;
    for (int i = 0; i < c_NSRC; i++) begin
      if (oh[i]) s = issue_src_t'(3'(i + 1));
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/llc_issue_prio_sel.sv
// ============================================================================
// Module : llc_issue_prio_sel
// Brief  : Combinational winner select: rst > rsp > resume > req/dma round-robin.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module llc_issue_prio_sel
  import llc_issue_arbiter_pkg::*;
(
  input  logic [c_NSRC-1:0] i_elig,
  input  logic              i_rr_dma,
  input  logic              i_rsp_skip,
  output logic [c_NSRC-1:0] o_winner
);

  always_comb begin
    o_winner = '0;
    if (i_elig[c_IDX_RST]) begin
      o_winner[c_IDX_RST] = 1'b1;
    end else if (i_elig[c_IDX_RSP] && !i_rsp_skip) begin
      o_winner[c_IDX_RSP] = 1'b1;
    end else if (i_elig[c_IDX_RESUME]) begin
      o_winner[c_IDX_RESUME] = 1'b1;
    end else if (i_elig[c_IDX_REQ] && i_elig[c_IDX_DMA]) begin
      // Pointer only matters when both contend.
      if (i_rr_dma) o_winner[c_IDX_DMA] = 1'b1;
      else          o_winner[c_IDX_REQ] = 1'b1;
    end else if (i_elig[c_IDX_REQ]) begin
      o_winner[c_IDX_REQ] = 1'b1;
    end else if (i_elig[c_IDX_DMA]) begin
      o_winner[c_IDX_DMA] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/llc_issue_arbiter.sv
// ============================================================================
// Module : llc_issue_arbiter
// Brief  : One-in-flight LLC issue scheduler with rsp burst limit and req/dma RR.
//          Optional grant statistics under LLC_ISSUE_ARB_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module llc_issue_arbiter
  import llc_issue_arbiter_pkg::*;
#(
  parameter int RSP_BURST_MAX = LLC_RSP_BURST_MAX,
  parameter int BUSY_TIMEOUT  = LLC_BUSY_TIMEOUT,
  parameter int SRC_W         = 3
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_tb_valid,
  output logic             rst_tb_ready,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             dma_valid,
  output logic             dma_ready,
  input  logic             req_stalled_valid,
  input  logic             req_block,
  input  logic             dma_block,
  input  logic             core_ready,
  input  logic             core_done,
  output logic             issue_valid,
  output logic [SRC_W-1:0] issue_src,
  output logic             busy,
  output logic             hang
`ifdef LLC_ISSUE_ARB_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      stat_rsp,
  output logic [31:0]      stat_req,
  output logic [31:0]      stat_dma,
  output logic [31:0]      stat_resume
`endif
);

  localparam int c_CNT_W  = $clog2(RSP_BURST_MAX + 1);
  localparam int c_BUSY_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_rsp_cnt;
  logic [c_BUSY_W-1:0] r_busy_cnt;
  logic                r_rr_dma;
  logic                r_hang;

  logic [c_NSRC-1:0]   w_elig;
  logic [c_NSRC-1:0]   w_winner;
  logic                w_others;
  logic                w_skip;
  logic                w_grant;
  issue_src_t          w_src;

  assign w_elig[c_IDX_RST]    = rst_tb_valid;
  assign w_elig[c_IDX_RSP]    = rsp_valid;
  assign w_elig[c_IDX_RESUME] = req_stalled_valid;
  assign w_elig[c_IDX_REQ]    = req_valid & ~req_block & ~req_stalled_valid;
  assign w_elig[c_IDX_DMA]    = dma_valid & ~dma_block;

  assign w_others = w_elig[c_IDX_RESUME] | w_elig[c_IDX_REQ] | w_elig[c_IDX_DMA];
  assign w_skip   = (r_rsp_cnt == c_CNT_W'(RSP_BURST_MAX)) && w_others;

  llc_issue_prio_sel u_prio_sel (
    .i_elig     (w_elig),
    .i_rr_dma   (r_rr_dma),
    .i_rsp_skip (w_skip),
    .o_winner   (w_winner)
  );

  // Gated by rst so nothing is offered while reset is held.
  assign w_grant = (r_state == ST_IDLE) && core_ready && !rst && (|w_elig);
  assign w_src   = onehot_to_src(w_winner);

  assign rst_tb_ready = w_grant & w_winner[c_IDX_RST];
  assign rsp_ready    = w_grant & w_winner[c_IDX_RSP];
  assign req_ready    = w_grant & w_winner[c_IDX_REQ];
  assign dma_ready    = w_grant & w_winner[c_IDX_DMA];
  assign issue_valid  = w_grant;
  assign issue_src    = w_grant ? SRC_W'(w_src) : '0;
  assign busy         = (r_state == ST_BUSY);
  assign hang         = r_hang;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rsp_cnt  <= '0;
      r_busy_cnt <= '0;
      r_rr_dma   <= 1'b0;
      r_hang     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state    <= ST_BUSY;
            r_busy_cnt <= '0;
            // rst grants leave the burst count alone unless nothing else is waiting.
            if (!w_others) begin
              r_rsp_cnt <= '0;
            end else if (w_winner[c_IDX_RSP]) begin
              if (r_rsp_cnt != c_CNT_W'(RSP_BURST_MAX))
                r_rsp_cnt <= r_rsp_cnt + c_CNT_W'(1);
            end else if (!w_winner[c_IDX_RST]) begin
              r_rsp_cnt <= '0;
            end
            if (w_winner[c_IDX_REQ])      r_rr_dma <= 1'b1;
            else if (w_winner[c_IDX_DMA]) r_rr_dma <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (r_busy_cnt != c_BUSY_W'(BUSY_TIMEOUT))
            r_busy_cnt <= r_busy_cnt + c_BUSY_W'(1);
          if (r_busy_cnt == c_BUSY_W'(BUSY_TIMEOUT - 1))
            r_hang <= 1'b1;
          if (core_done)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef LLC_ISSUE_ARB_STATS_EN
  logic [31:0] r_stat_rsp;
  logic [31:0] r_stat_req;
  logic [31:0] r_stat_dma;
  logic [31:0] r_stat_resume;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_rsp    <= '0;
      r_stat_req    <= '0;
      r_stat_dma    <= '0;
      r_stat_resume <= '0;
    end else if (stat_clr) begin
      r_stat_rsp    <= '0;
      r_stat_req    <= '0;
      r_stat_dma    <= '0;
      r_stat_resume <= '0;
    end else if (w_grant) begin
      if (w_winner[c_IDX_RSP])    r_stat_rsp    <= r_stat_rsp + 32'd1;
      if (w_winner[c_IDX_REQ])    r_stat_req    <= r_stat_req + 32'd1;
      if (w_winner[c_IDX_DMA])    r_stat_dma    <= r_stat_dma + 32'd1;
      if (w_winner[c_IDX_RESUME]) r_stat_resume <= r_stat_resume + 32'd1;
    end
  end

  assign stat_rsp    = r_stat_rsp;
  assign stat_req    = r_stat_req;
  assign stat_dma    = r_stat_dma;
  assign stat_resume = r_stat_resume;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_llc_issue_arbiter.sv
// ============================================================================
// Module : tb_llc_issue_arbiter
// Brief  : Scoreboard bench for llc_issue_arbiter grant order, timeout and reset.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_llc_issue_arbiter;

  localparam int c_TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_tb_valid, rsp_valid, req_valid, dma_valid;
  logic       req_stalled_valid, req_block, dma_block, core_ready, core_done;
  logic       rst_tb_ready, rsp_ready, req_ready, dma_ready;
  logic       issue_valid, busy, hang;
  logic [2:0] issue_src;
`ifdef LLC_ISSUE_ARB_STATS_EN
  logic [31:0] stat_rsp, stat_req, stat_dma, stat_resume;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];
  int         done_cd;
  logic       g_valid;
  logic [2:0] g_src;
  logic [3:0] g_rdy;

  always #5 clk = ~clk;

  llc_issue_arbiter #(
    .RSP_BURST_MAX (4),
    .BUSY_TIMEOUT  (c_TIMEOUT),
    .SRC_W         (3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rst_tb_valid      (rst_tb_valid),
    .rst_tb_ready      (rst_tb_ready),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .dma_valid         (dma_valid),
    .dma_ready         (dma_ready),
    .req_stalled_valid (req_stalled_valid),
    .req_block         (req_block),
    .dma_block         (dma_block),
    .core_ready        (core_ready),
    .core_done         (core_done),
    .issue_valid       (issue_valid),
    .issue_src         (issue_src),
    .busy              (busy),
    .hang              (hang)
`ifdef LLC_ISSUE_ARB_STATS_EN
    ,
    .stat_clr          (1'b0),
    .stat_rsp          (stat_rsp),
    .stat_req          (stat_req),
    .stat_dma          (stat_dma),
    .stat_resume       (stat_resume)
`endif
  );

  // Ready pattern {rst,rsp,req,dma} a grant of the given source must show.
  function automatic logic [3:0] exp_rdy(input logic [2:0] s);
    case (s)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0100;
      3'd4:    return 4'b0010;
      3'd5:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic drive_idle;
    rst_tb_valid = 0; rsp_valid = 0; req_valid = 0; dma_valid = 0;
    req_stalled_valid = 0; req_block = 0; dma_block = 0;
    core_ready = 0; core_done = 0;
  endtask

  task automatic do_reset;
    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cd = 0;
  endtask

  // One cycle of stimulus: pulses core_done three cycles after each grant,
  // captures the grant outputs, then advances to the next falling edge.
  task automatic cycle_step;
    core_done = 1'b0;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) core_done = 1'b1;
    end
    #1;
    g_valid = issue_valid;
    g_src   = issue_src;
    g_rdy   = {rst_tb_ready, rsp_ready, req_ready, dma_ready};
    if (issue_valid) done_cd = 3;
    @(negedge clk);
  endtask

  task automatic test_reset;
    drive_idle();
    rst_tb_valid = 1; rsp_valid = 1; req_valid = 1; dma_valid = 1; core_ready = 1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if ({rst_tb_ready, rsp_ready, req_ready, dma_ready, issue_valid, issue_src, busy, hang} !== 10'd0) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: got rdy=%b iv=%b src=%0d busy=%b hang=%b, required all 0",
                 k, {rst_tb_ready, rsp_ready, req_ready, dma_ready}, issue_valid, issue_src, busy, hang);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_burst;
    int seen = 0;
    int cyc  = 0;
    logic [2:0] e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      repeat (4) exp_q.push_back(3'd2);
      exp_q.push_back(3'd4);
    end
    core_ready = 1; rsp_valid = 1; req_valid = 1;
    while (exp_q.size() > 0 && cyc < 200) begin
      cycle_step(); cyc++;
      if (g_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (g_src !== e || g_rdy !== exp_rdy(e)) begin
          n_err++;
          $display("FAIL burst grant %0d: got src=%0d rdy=%b, required src=%0d rdy=%b", seen, g_src, g_rdy, e, exp_rdy(e));
        end
        seen++;
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL burst timeout: %0d grants missing, required 0", exp_q.size());
      exp_q.delete();
    end
    drive_idle();
  endtask

  task automatic test_rr;
    int seen = 0;
    int cyc  = 0;
    logic [2:0] e;
    do_reset();
    exp_q.push_back(3'd4); exp_q.push_back(3'd5);
    exp_q.push_back(3'd4); exp_q.push_back(3'd5);
    core_ready = 1; req_valid = 1; dma_valid = 1;
    while (exp_q.size() > 0 && cyc < 100) begin
      cycle_step(); cyc++;
      if (g_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (g_src !== e || g_rdy !== exp_rdy(e)) begin
          n_err++;
          $display("FAIL rr grant %0d: got src=%0d rdy=%b, required src=%0d rdy=%b", seen, g_src, g_rdy, e, exp_rdy(e));
        end
        seen++;
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rr timeout: %0d grants missing, required 0", exp_q.size());
      exp_q.delete();
    end
    drive_idle();
  endtask

  // rst arrives once the rsp burst is exhausted; it must win and leave the
  // exhausted count in place, so req follows before rsp resumes.
  task automatic test_rst_prio;
    int seen = 0;
    int cyc  = 0;
    logic [2:0] e;
    do_reset();
    repeat (4) exp_q.push_back(3'd2);
    exp_q.push_back(3'd1); exp_q.push_back(3'd4); exp_q.push_back(3'd2);
    core_ready = 1; rsp_valid = 1; req_valid = 1;
    while (exp_q.size() > 0 && cyc < 150) begin
      rst_tb_valid = (seen == 4);
      cycle_step(); cyc++;
      if (g_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (g_src !== e || g_rdy !== exp_rdy(e)) begin
          n_err++;
          $display("FAIL rst_prio grant %0d: got src=%0d rdy=%b, required src=%0d rdy=%b", seen, g_src, g_rdy, e, exp_rdy(e));
        end
        seen++;
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_prio timeout: %0d grants missing, required 0", exp_q.size());
      exp_q.delete();
    end
    drive_idle();
  endtask

  task automatic test_resume;
    int seen = 0;
    int cyc  = 0;
    logic [2:0] e;
    do_reset();
    exp_q.push_back(3'd3); exp_q.push_back(3'd4);
    core_ready = 1; req_valid = 1;
    while (exp_q.size() > 0 && cyc < 60) begin
      req_stalled_valid = (seen == 0);
      cycle_step(); cyc++;
      if (g_valid) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (g_src !== e || g_rdy !== exp_rdy(e)) begin
          n_err++;
          $display("FAIL resume grant %0d: got src=%0d rdy=%b, required src=%0d rdy=%b", seen, g_src, g_rdy, e, exp_rdy(e));
        end
        seen++;
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL resume timeout: %0d grants missing, required 0", exp_q.size());
      exp_q.delete();
    end
    drive_idle();
  endtask

  task automatic test_hang;
    do_reset();
    core_ready = 1; req_valid = 1;
    #1;
    n_cmp++;
    if (issue_valid !== 1'b1 || issue_src !== 3'd4) begin
      n_err++;
      $display("FAIL hang_grant: got iv=%b src=%0d, required iv=1 src=4", issue_valid, issue_src);
    end
    @(negedge clk);
    req_valid = 0;
    repeat (c_TIMEOUT - 1) @(negedge clk);
    #1;
    n_cmp++;
    if (hang !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL hang_early: got hang=%b busy=%b after %0d busy cycles, required hang=0 busy=1", hang, busy, c_TIMEOUT - 1);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (hang !== 1'b1) begin
      n_err++;
      $display("FAIL hang_set: got hang=%b after %0d busy cycles, required 1", hang, c_TIMEOUT);
    end
    core_done = 1;
    @(negedge clk);
    core_done = 0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || hang !== 1'b1) begin
      n_err++;
      $display("FAIL hang_sticky: got busy=%b hang=%b after core_done, required busy=0 hang=1", busy, hang);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (hang !== 1'b0) begin
      n_err++;
      $display("FAIL hang_reset: got hang=%b in reset, required 0", hang);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_rst_busy;
    do_reset();
    core_ready = 1; req_valid = 1;
    #1;
    n_cmp++;
    if (issue_valid !== 1'b1 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_busy_grant: got iv=%b req_ready=%b, required 1/1", issue_valid, req_ready);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1 || issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_busy_inflight: got busy=%b iv=%b, required busy=1 iv=0", busy, issue_valid);
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if ({rst_tb_ready, rsp_ready, req_ready, dma_ready, issue_valid, issue_src, busy, hang} !== 10'd0) begin
        n_err++;
        $display("FAIL rst_busy_hold[%0d]: got rdy=%b iv=%b src=%0d busy=%b, required all 0",
                 k, {rst_tb_ready, rsp_ready, req_ready, dma_ready}, issue_valid, issue_src, busy);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (issue_valid !== 1'b1 || issue_src !== 3'd4 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_busy_release: got iv=%b src=%0d req_ready=%b, required 1/4/1", issue_valid, issue_src, req_ready);
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    done_cd = 0;
    @(negedge clk);
    test_reset();
    test_burst();
    test_rr();
    test_rst_prio();
    test_resume();
    test_hang();
    test_rst_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded 1 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
